// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns
//             the PC, drives a synchronous-read instruction memory and holds
//             the IF/ID pipeline register. A captured instruction is replayed
//             during stalls, so the memory need not hold its output.
//  Ports    : clk, rst                    - clock, sync active-high reset
//             hazardFEEnable              - 1 = fetch/IF/ID advance, 0 = hold
//             hazardIFIDClear             - 1 = IF/ID becomes a bubble
//             branch_taken_in/_target_in  - redirect request from ID
//             imem_addr_out/imem_rd_en_out/imem_data_in - memory port
//             ifid_instr_out/_pc_out/_pc_plus4_out/_valid_out - IF/ID outputs
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazardFEEnable,
  input  logic        hazardIFIDClear,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  output logic [31:0] imem_addr_out,
  output logic        imem_rd_en_out,
  input  logic [31:0] imem_data_in,
  output logic [31:0] ifid_instr_out,
  output logic [31:0] ifid_pc_out,
  output logic [31:0] ifid_pc_plus4_out,
  output logic        ifid_valid_out
);

  logic [31:0] pc_q;
  logic [31:0] resp_pc_q;
  logic        resp_valid_q;
  logic [31:0] hold_instr_q;
  logic        hold_valid_q;

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      resp_pc_q    <= 32'd0;
      resp_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
    end else if (branch_taken_in) begin
      // Redirect: the read issued this cycle (if any) is discarded.
      pc_q         <= {branch_target_in[31:2], 2'b00};
      resp_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
    end else if (hazardIFIDClear) begin
      resp_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
      // With fetch enabled the word being read is dropped; otherwise the
      // same PC is fetched again once the stall lifts.
      if (hazardFEEnable) begin
        pc_q <= pc_plus4;
      end
    end else if (!hazardFEEnable) begin
      // First stall cycle: the memory output is still the IF/ID word, so
      // capture it before the memory moves on.
      if (resp_valid_q && !hold_valid_q) begin
        hold_instr_q <= imem_data_in;
        hold_valid_q <= 1'b1;
      end
    end else begin
      pc_q         <= pc_plus4;
      resp_pc_q    <= pc_q;
      resp_valid_q <= 1'b1;
      hold_valid_q <= 1'b0;
    end
  end

  assign imem_addr_out     = pc_q;
  assign imem_rd_en_out    = hazardFEEnable & ~branch_taken_in & ~rst;

  assign ifid_valid_out    = resp_valid_q;
  assign ifid_pc_out       = resp_pc_q;
  assign ifid_pc_plus4_out = resp_pc_q + 32'd4;
  assign ifid_instr_out    = hold_valid_q ? hold_instr_q :
                             (resp_valid_q ? imem_data_in : NOP_INSTR);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage. The memory model
//             returns addr + 0x1000_0000 one cycle after a strobed read and
//             0xDEADBEEF when the strobe is low.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazardFEEnable;
  logic        hazardIFIDClear;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic [31:0] imem_addr_out;
  logic        imem_rd_en_out;
  logic [31:0] imem_data_in;
  logic [31:0] ifid_instr_out;
  logic [31:0] ifid_pc_out;
  logic [31:0] ifid_pc_plus4_out;
  logic        ifid_valid_out;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .hazardFEEnable   (hazardFEEnable),
    .hazardIFIDClear  (hazardIFIDClear),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .imem_addr_out    (imem_addr_out),
    .imem_rd_en_out   (imem_rd_en_out),
    .imem_data_in     (imem_data_in),
    .ifid_instr_out   (ifid_instr_out),
    .ifid_pc_out      (ifid_pc_out),
    .ifid_pc_plus4_out(ifid_pc_plus4_out),
    .ifid_valid_out   (ifid_valid_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    imem_data_in <= imem_rd_en_out ? (imem_addr_out + 32'h1000_0000) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge.
  task automatic drive(input logic r, input logic fe, input logic clr,
                       input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst              = r;
    hazardFEEnable   = fe;
    hazardIFIDClear  = clr;
    branch_taken_in  = br;
    branch_target_in = tgt;
  endtask

  // Let the driven cycle complete, then sample 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hazardFEEnable = 1'b0; hazardIFIDClear = 1'b0;
    branch_taken_in = 1'b0; branch_target_in = 32'h0;

    // ---------------- reset, two cycles ----------------
    drive(1, 1, 0, 0, 0); tick;
    drive(1, 1, 0, 0, 0); tick;
    chk("rst_valid",  {31'd0, ifid_valid_out}, 32'd0);
    chk("rst_instr",  ifid_instr_out,          32'h0000_0013);
    chk("rst_pc",     ifid_pc_out,             32'h0);
    chk("rst_pc4",    ifid_pc_plus4_out,       32'h4);
    chk("rst_addr",   imem_addr_out,           32'h100);
    chk("rst_rden",   {31'd0, imem_rd_en_out}, 32'd0);

    // ---------------- sequential fetch ----------------
    drive(0, 1, 0, 0, 0);
    #1 chk("seq_rden", {31'd0, imem_rd_en_out}, 32'd1);
    tick;
    chk("seq0_pc",    ifid_pc_out,             32'h100);
    chk("seq0_instr", ifid_instr_out,          32'h1000_0100);
    chk("seq0_valid", {31'd0, ifid_valid_out}, 32'd1);
    drive(0, 1, 0, 0, 0); tick;
    chk("seq1_pc",    ifid_pc_out,             32'h104);
    chk("seq1_instr", ifid_instr_out,          32'h1000_0104);

    // ---------------- 3-cycle load-use stall ----------------
    drive(0, 0, 0, 0, 0);
    #1 chk("stall_rden", {31'd0, imem_rd_en_out}, 32'd0);
    tick;
    chk("stall1_instr", ifid_instr_out, 32'h1000_0104);
    chk("stall1_pc",    ifid_pc_out,    32'h104);
    drive(0, 0, 0, 0, 0); tick;
    chk("stall2_instr", ifid_instr_out, 32'h1000_0104);
    chk("stall2_valid", {31'd0, ifid_valid_out}, 32'd1);
    drive(0, 0, 0, 0, 0); tick;
    chk("stall3_instr", ifid_instr_out, 32'h1000_0104);
    chk("stall3_addr",  imem_addr_out,  32'h108);
    drive(0, 1, 0, 0, 0); tick;
    chk("rel_pc",    ifid_pc_out,    32'h108);
    chk("rel_instr", ifid_instr_out, 32'h1000_0108);

    // ---------------- control hazard at pc_q = 0x20C ----------------
    drive(0, 1, 0, 1, 32'h208);
    #1 chk("br208_rden", {31'd0, imem_rd_en_out}, 32'd0);
    tick;
    chk("br208_addr",  imem_addr_out,           32'h208);
    chk("br208_valid", {31'd0, ifid_valid_out}, 32'd0);
    drive(0, 1, 0, 0, 0); tick;
    chk("pre_clr_addr", imem_addr_out, 32'h20C);
    drive(0, 0, 1, 0, 0); tick;
    chk("clr_valid", {31'd0, ifid_valid_out}, 32'd0);
    chk("clr_instr", ifid_instr_out,          32'h0000_0013);
    chk("clr_addr",  imem_addr_out,           32'h20C);
    drive(0, 1, 0, 0, 0); tick;
    chk("refetch_pc",    ifid_pc_out,             32'h20C);
    chk("refetch_instr", ifid_instr_out,          32'h1000_020C);
    chk("refetch_valid", {31'd0, ifid_valid_out}, 32'd1);

    // ---------------- branch redirect, unaligned target ----------------
    drive(0, 1, 0, 1, 32'h403); tick;
    chk("br400_addr",  imem_addr_out,           32'h400);
    chk("br400_valid", {31'd0, ifid_valid_out}, 32'd0);
    chk("br400_instr", ifid_instr_out,          32'h0000_0013);
    drive(0, 1, 0, 0, 0); tick;
    chk("tgt_pc",    ifid_pc_out,             32'h400);
    chk("tgt_pc4",   ifid_pc_plus4_out,       32'h404);
    chk("tgt_instr", ifid_instr_out,          32'h1000_0400);
    chk("tgt_valid", {31'd0, ifid_valid_out}, 32'd1);

    // ---------------- priority: branch + clear + stall ----------------
    drive(0, 0, 1, 1, 32'h80); tick;
    chk("prio_addr",  imem_addr_out,           32'h80);
    chk("prio_valid", {31'd0, ifid_valid_out}, 32'd0);
    drive(0, 0, 0, 0, 0); tick;
    chk("prio_noreplay_instr", ifid_instr_out,          32'h0000_0013);
    chk("prio_noreplay_valid", {31'd0, ifid_valid_out}, 32'd0);
    drive(0, 1, 0, 0, 0); tick;
    chk("prio_pc",    ifid_pc_out,    32'h80);
    chk("prio_instr", ifid_instr_out, 32'h1000_0080);

    // ---------------- PC wrap ----------------
    drive(0, 1, 0, 1, 32'hFFFF_FFFC); tick;
    drive(0, 1, 0, 0, 0); tick;
    chk("wrap_pc",    ifid_pc_out,       32'hFFFF_FFFC);
    chk("wrap_pc4",   ifid_pc_plus4_out, 32'h0);
    chk("wrap_instr", ifid_instr_out,    32'h0FFF_FFFC);
    chk("wrap_addr",  imem_addr_out,     32'h0);
    drive(0, 1, 0, 0, 0); tick;
    chk("wrap_next_pc",    ifid_pc_out,    32'h0);
    chk("wrap_next_instr", ifid_instr_out, 32'h1000_0000);

    // ---------------- reset in the middle of a stall ----------------
    drive(0, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 0, 0); tick;
    chk("pre_rst_replay", ifid_instr_out, 32'h1000_0000);
    drive(1, 0, 0, 0, 0); tick;
    chk("mrst_valid", {31'd0, ifid_valid_out}, 32'd0);
    chk("mrst_instr", ifid_instr_out,          32'h0000_0013);
    chk("mrst_pc",    ifid_pc_out,             32'h0);
    chk("mrst_pc4",   ifid_pc_plus4_out,       32'h4);
    chk("mrst_addr",  imem_addr_out,           32'h100);
    chk("mrst_rden",  {31'd0, imem_rd_en_out}, 32'd0);
    drive(0, 1, 0, 0, 0); tick;
    chk("post_rst_pc",    ifid_pc_out,    32'h100);
    chk("post_rst_instr", ifid_instr_out, 32'h1000_0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the 5-stage RISC-V pipeline. It owns the PC register, drives the synchronous-read instruction memory, and holds the IF/ID pipeline register that feeds decode. It consumes `hazardFEEnable` and `hazardIFIDClear` from `hazard_unit` and the branch redirect from ID. It replays a captured instruction during stalls, so correctness never depends on the memory holding its output.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction driven on `ifid_instr_out` when the IF/ID register is invalid (`addi x0,x0,0`).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `hazardFEEnable`  in  1: 1 = fetch and IF/ID advance; 0 = hold PC and IF/ID.
- `hazardIFIDClear`  in  1: 1 = IF/ID becomes a bubble next cycle.
- `branch_taken_in`  in  1: redirect request from ID, single-cycle pulse.
- `branch_target_in`  in  32: redirect target; bits [1:0] ignored (treated as 0).
- `imem_addr_out`  out  32: instruction address, equal to `pc_q`.
- `imem_rd_en_out`  out  1: read strobe, equal to `hazardFEEnable & ~branch_taken_in & ~rst`.
- `imem_data_in`  in  32: read data, valid the cycle after the strobed address.
- `ifid_instr_out`  out  32: ID-stage instruction.
- `ifid_pc_out`  out  32: PC of `ifid_instr_out`.
- `ifid_pc_plus4_out`  out  32: `ifid_pc_out + 4`, modulo 2^32.
- `ifid_valid_out`  out  1: 1 = IF/ID holds a real instruction.

## Operation
- Registers: `pc_q`, `resp_pc_q`, `resp_valid_q`, `hold_instr_q`, `hold_valid_q`.
- `ifid_valid_out` = `resp_valid_q`. `ifid_pc_out` = `resp_pc_q`.
- `ifid_instr_out` is selected as follows:
  - `hold_instr_q` if `hold_valid_q`;
  - otherwise `imem_data_in` if `resp_valid_q`;
  - otherwise `NOP_INSTR`.
- Per-edge update. Exactly one rule applies, in priority order:
  1. `rst`: `pc_q`←`RESET_PC`, `resp_pc_q`←0, `resp_valid_q`←0, `hold_valid_q`←0, `hold_instr_q`←`NOP_INSTR`.
  2. `branch_taken_in`: `pc_q`←{`branch_target_in[31:2]`,2'b00}, `resp_valid_q`←0, `hold_valid_q`←0. Any in-flight read is discarded.
  3. `hazardIFIDClear`: `resp_valid_q`←0, `hold_valid_q`←0. If `hazardFEEnable`=1, `pc_q`←`pc_q`+4 and the fetched word is dropped. If `hazardFEEnable`=0, `pc_q` holds and is refetched later.
  4. `~hazardFEEnable` (stall): `pc_q`, `resp_pc_q` and `resp_valid_q` hold. If `resp_valid_q & ~hold_valid_q`, then `hold_instr_q`←`imem_data_in` and `hold_valid_q`←1.
  5. Advance: `pc_q`←`pc_q`+4, `resp_pc_q`←`pc_q`, `resp_valid_q`←1, `hold_valid_q`←0.
- Arithmetic: all PC adds are 32-bit and wrap (0xFFFF_FFFC+4 = 0). There are no misalignment traps.
- The block has no FSM beyond the hold flag. It is either in the normal state or in replay (`hold_valid_q`=1); replay exits on any advance, clear, branch or reset.

## Timing
- Reset values of the outputs:
  - `imem_addr_out`=`RESET_PC`, `imem_rd_en_out`=0 while `rst`=1;
  - `ifid_valid_out`=0, `ifid_instr_out`=`NOP_INSTR`, `ifid_pc_out`=0, `ifid_pc_plus4_out`=4.
- First valid instruction: the cycle after reset, `RESET_PC` is presented. If `hazardFEEnable`=1, `ifid_valid_out`=1 with `ifid_pc_out`=`RESET_PC` one cycle later.
- Throughput: one instruction per cycle while `hazardFEEnable`=1 and no clear or branch is present.
- Stall:
  - While stalled, IF/ID outputs are bit-stable from the first stall cycle. `ifid_instr_out` comes from the hold register from the second stall cycle onward.
  - On release, the next instruction (`resp_pc_q`+4) appears exactly one cycle later. No instruction is lost or duplicated.
- Redirect: if `branch_taken_in` is asserted in cycle N, `imem_addr_out`=target in N+1. `ifid_valid_out`=0 in N+1. The target instruction is valid in N+2, given `hazardFEEnable`=1 in N+1.
- Simultaneous events: `branch_taken_in` overrides clear and stall. Clear overrides stall. A load-use stall (`hazardFEEnable`=0) with clear=0 never drops IF/ID contents.
- Reset mid-stall or mid-redirect discards the hold register and the pending target. The reset rule applies unconditionally.

## Test plan
- Reset and sequential fetch: hold `rst` 2 cycles with `RESET_PC`=0x100, then `hazardFEEnable`=1. Expect `ifid_pc_out` 0x100, 0x104, 0x108 on consecutive cycles, with `ifid_instr_out` matching the memory words and `ifid_valid_out`=1.
- Load-use stall with replay: drop `hazardFEEnable` for 3 cycles while IF/ID holds pc 0x104. The memory model drives 0xDEADBEEF whenever `imem_rd_en_out`=0. Expect `ifid_instr_out` to stay at the 0x104 word, `imem_rd_en_out`=0, and pc 0x108 to appear one cycle after release.
- Control hazard: `hazardIFIDClear`=1 and `hazardFEEnable`=0 for 1 cycle with `pc_q`=0x20C. Expect `ifid_valid_out`=0 and `ifid_instr_out`=0x00000013 next cycle, then 0x20C fetched and valid after re-enable.
- Branch redirect: pulse `branch_taken_in` with target 0x403 in cycle N. Expect `imem_addr_out`=0x400 in N+1, a bubble in N+1, `ifid_pc_out`=0x400 valid in N+2, and `ifid_pc_plus4_out`=0x404.
- Priority: assert `branch_taken_in`, `hazardIFIDClear` and `hazardFEEnable`=0 together, target 0x80. Expect the redirect to 0x80 to occur and no hold-register replay afterwards.
- Wrap and reset-mid-stall: a branch to 0xFFFFFFFC then advance gives `ifid_pc_plus4_out`=0 and the next `ifid_pc_out`=0. Asserting `rst` during a stall gives all outputs at reset values next cycle.
